vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, scanout prefetch FIFO entries (power of two).
REQ-004 SHALL have port clk  in  1  50 MHz system clock.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port pix_en  in  1  one-clk 25 MHz pixel strobe from the timing generator.
REQ-007 SHALL have port line_start  in  1  one-clk pulse in hblank before each line.
REQ-008 SHALL have port line_y  in  10  line index, sampled with line_start.
REQ-009 SHALL have port de  in  1  display-area flag, qualified by pix_en.
REQ-010 SHALL have port rgb_out  out  3  registered pixel colour.
REQ-011 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in 19, wr_data in 3: writer request channel.
REQ-012 SHALL have ports mem_addr out 19, mem_we out 1, mem_wdata out 3, mem_rdata in 3: single-port framebuffer SRAM with 1-clk read latency.

Function
REQ-013 SHALL use pixel address y*H_ACTIVE+x.
REQ-014 SHALL implement FSM IDLE/FETCH: IDLE->FETCH on line_start with line_y<V_ACTIVE; FETCH->IDLE when H_ACTIVE reads are issued; line_start with line_y>=V_ACTIVE leaves FSM in IDLE.
REQ-015 SHALL, on FETCH entry, flush FIFO, load the read address with line_y*H_ACTIVE and the remaining count with H_ACTIVE.
REQ-016 SHALL issue one read per clk in FETCH while FIFO level plus in-flight reads < FIFO_DEPTH; read has priority over writer.
REQ-017 SHALL grant the writer (wr_ready=1, combinational from state) in any clk with no read issued; transfer occurs when wr_valid&&wr_ready and drives mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in that clk.
REQ-018 SHALL push mem_rdata into FIFO exactly one clk after each read.
REQ-019 SHALL pop one entry and register it on rgb_out when pix_en&&de and FIFO non-empty.
REQ-020 SHALL register rgb_out=0 when pix_en&&!de; rgb_out holds between pix_en strobes.
REQ-021 SHALL register rgb_out=0 when pix_en&&de and FIFO empty (underrun), with no pop.
REQ-022 SHALL, on line_start during FETCH, abort the fetch, discard the pending read return, flush, and restart per REQ-015.
REQ-023 SHALL handle simultaneous push and pop in one clk with level unchanged.
REQ-024 SHALL keep mem_we=0 whenever no write is granted.

Reset
REQ-025 SHALL, with rst=0 at a clk edge, force FSM=IDLE, FIFO empty, in-flight cleared, rgb_out=0, mem_we=0, mem_addr=0, wr_ready=0; effective mid-fetch or mid-line.

Configuration
REQ-026 SHALL, with FB_ARB_UNDERRUN_EN defined, add output underrun (1 bit), set sticky on any REQ-021 event and cleared only by reset.
REQ-027 SHALL, without FB_ARB_UNDERRUN_EN, omit the underrun port and its logic; all other behaviour identical.

Structure
REQ-028 SHALL place H_ACTIVE/V_ACTIVE defaults, address width 19, pixel width 3 and state enum in shared package vga_pkg.
REQ-029 SHALL implement the prefetch FIFO as sub-module vga_line_fifo (synchronous, level output, flush input).

Verification
REQ-030 SHALL test: reset, line_start line_y=5 -> first mem_addr=3200, 640 reads, FSM returns IDLE.
REQ-031 SHALL test: SRAM preloaded addr=value%8, de for 640 strobes -> rgb_out sequence matches, no underrun.
REQ-032 SHALL test: wr_valid held during FETCH -> writes occur only in no-read clks, all writes land, zero scanout loss.
REQ-033 SHALL test: de asserted 1 clk after line_start -> underrun flag set, rgb_out=0 for empty strobes.
REQ-034 SHALL test: second line_start after 100 reads -> FIFO flushed, mem_addr restarts at new line base.
REQ-035 SHALL test: line_start line_y=480 -> no reads, wr_ready=1 continuously.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: default geometry,
// framebuffer bus widths and the fetch FSM state encoding.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ADDR_W       = 19;
    localparam int PIX_W        = 3;

    typedef logic [0:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 1'b0;
    localparam fsm_state_t ST_FETCH = 1'b1;

endpackage

// File: rtl/vga_line_fifo.sv
// Synchronous scanout prefetch FIFO with show-ahead output, level count and a
// flush input that overrides push and pop in the same clock.
module vga_line_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = PIX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            din_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q;
    logic              do_push, do_pop;

    assign do_push = rst && !flush_i && push_i && (level_q != FULL_LVL);
    assign do_pop  = rst && !flush_i && pop_i && (level_q != '0);

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + ONE_LVL;
                2'b01:   level_q <= level_q - ONE_LVL;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer SRAM arbiter: line prefetch for scanout (priority) with writer
// access in idle clocks. Optional sticky underrun output: FB_ARB_UNDERRUN_EN.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              line_start,
    input  logic [9:0]        line_y,
    input  logic              de,
    output logic [PIX_W-1:0]  rgb_out,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
`ifdef FB_ARB_UNDERRUN_EN
    ,
    output logic              underrun
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(H_ACTIVE + 1);

    fsm_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0]     remain_q, remain_d;
    logic              inflight_q;
    logic [PIX_W-1:0]  rgb_q;

    logic [ADDR_W-1:0] line_base;
    logic              line_ok, rd_issue, wr_go, pop, fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic [LW:0]       occupancy;
    logic [PIX_W-1:0]  fifo_dout;

    assign line_ok   = int'(line_y) < V_ACTIVE;
    assign line_base = ADDR_W'(line_y) * ADDR_W'(H_ACTIVE);
    assign occupancy = (LW + 1)'(fifo_level) + (LW + 1)'(inflight_q);

    // No read in a line_start clock: that clock reloads the fetch for the new line.
    assign rd_issue = rst && !line_start && (state_q == ST_FETCH) &&
                      (remain_q != '0) && (occupancy < (LW + 1)'(FIFO_DEPTH));

    assign wr_ready  = rst && !rd_issue;
    assign wr_go     = wr_valid && wr_ready;
    assign mem_we    = wr_go;
    assign mem_addr  = rd_issue ? rd_addr_q : (wr_go ? wr_addr : '0);
    assign mem_wdata = wr_go ? wr_data : '0;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        remain_d  = remain_q;
        if (line_start) begin
            if (line_ok) begin
                state_d   = ST_FETCH;
                rd_addr_d = line_base;
                remain_d  = CW'(H_ACTIVE);
            end else begin
                state_d   = ST_IDLE;
            end
        end else if (rd_issue) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            remain_d  = remain_q - CW'(1);
            if (remain_q == CW'(1)) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            remain_q   <= remain_d;
            inflight_q <= rd_issue;
        end
    end

    // The flush on line_start also drops a read return landing in that clock.
    vga_line_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (line_start),
        .push_i  (inflight_q),
        .din_i   (mem_rdata),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .empty_o (fifo_empty)
    );

    assign pop = pix_en && de && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_q <= '0;
        end else if (pix_en) begin
            rgb_q <= pop ? fifo_dout : '0;
        end
    end

    assign rgb_out = rgb_q;

`ifdef FB_ARB_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            underrun_q <= 1'b0;
        end else if (pix_en && de && fifo_empty) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter; SRAM model returns addr%8 unless written.
// Underrun flag checks are compiled in with FB_ARB_UNDERRUN_EN.
module tb_vga_fb_arbiter;

    localparam int NPIX  = 307200;
    localparam int WBASE = 100000;
    localparam int NW    = 20;

    logic        clk = 1'b0;
    logic        rst, pix_en, line_start, de, wr_valid;
    logic [9:0]  line_y;
    logic [2:0]  rgb_out, wr_data, mem_wdata, mem_rdata;
    logic        wr_ready, mem_we;
    logic [18:0] wr_addr, mem_addr;
`ifdef FB_ARB_UNDERRUN_EN
    logic        underrun;
`endif

    vga_fb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .line_start (line_start),
        .line_y     (line_y),
        .de         (de),
        .rgb_out    (rgb_out),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef FB_ARB_UNDERRUN_EN
        ,
        .underrun   (underrun)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model with one clock read latency
    bit       written [0:NPIX-1];
    bit [2:0] wval    [0:NPIX-1];

    function automatic logic [2:0] sram_rd(input logic [18:0] a);
        if (int'(a) < NPIX && written[a]) return wval[a];
        return a[2:0];
    endfunction

    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < NPIX) begin
            written[mem_addr] <= 1'b1;
            wval[mem_addr]    <= mem_wdata;
        end
        mem_rdata <= sram_rd(mem_addr);
    end

    // Bus monitor, sampled on the falling edge
    logic       clr;
    int         rd_cnt, seq_err, werr, wr_tot;
    logic [18:0] first_addr, exp_next;
    logic [2:0] cap [$];
    bit         pend;

    initial begin
        rd_cnt = 0; seq_err = 0; werr = 0; wr_tot = 0;
        first_addr = '0; exp_next = '0; pend = 1'b0;
    end

    always @(negedge clk) begin
        if (clr) begin
            rd_cnt = 0; seq_err = 0; werr = 0;
            cap.delete();
        end else begin
            if (pend) cap.push_back(rgb_out);
            if (rst && !wr_ready) begin
                rd_cnt++;
                if (rd_cnt == 1) first_addr = mem_addr;
                else if (mem_addr !== exp_next) seq_err++;
                exp_next = mem_addr + 19'd1;
                if (mem_we) werr++;
            end
            if (mem_we) begin
                wr_tot++;
                if (!wr_ready || !wr_valid || mem_addr !== wr_addr || mem_wdata !== wr_data) werr++;
            end
            if (rst && wr_valid && wr_ready && !mem_we) werr++;
        end
        pend = rst && pix_en && de;
    end

    int  ncmp = 0, nfail = 0;
    bit  wdrive = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pix_en = ~pix_en;
        if (wdrive) begin
            wr_addr = 19'(WBASE + wr_tot);
            wr_data = 3'((wr_tot + 3) % 8);
            wr_valid = (wr_tot < NW);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic start_line(input int y);
        line_y = 10'(y);
        line_start = 1'b1;
        clr = 1'b1;
        step();
        line_start = 1'b0;
        clr = 1'b0;
    endtask

    task automatic check_scan(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n && i < cap.size(); i++)
            if (cap[i] !== 3'(i % 8)) bad++;
        check({tag, "_count"}, cap.size(), n);
        check({tag, "_data"}, bad, 0);
    endtask

    initial begin
        int bad;
        rst = 1'b0; pix_en = 1'b0; line_start = 1'b0; de = 1'b0;
        line_y = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;

        // Reset state
        steps(3);
        check("rst_rgb", rgb_out, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wr_ready", wr_ready, 0);
        rst = 1'b1;
        step();
        check("idle_wr_ready", wr_ready, 1);

        // Line 5: 640 reads from 3200, full scanout
        start_line(5);
        steps(20);
        de = 1'b1;
        steps(1280);
        de = 1'b0;
        steps(10);
        check("l5_first_addr", first_addr, 3200);
        check("l5_reads", rd_cnt, 640);
        check("l5_seq", seq_err, 0);
        check("l5_idle", wr_ready, 1);
        check_scan("l5_scan", 640);
`ifdef FB_ARB_UNDERRUN_EN
        check("l5_no_underrun", underrun, 0);
`endif

        // Line 7 with the writer held valid throughout
        wdrive = 1'b1;
        wr_valid = 1'b1;
        wr_addr = 19'(WBASE);
        wr_data = 3'd3;
        start_line(7);
        steps(20);
        de = 1'b1;
        steps(1280);
        de = 1'b0;
        steps(10);
        wdrive = 1'b0;
        wr_valid = 1'b0;
        check("l7_first_addr", first_addr, 4480);
        check("l7_reads", rd_cnt, 640);
        check("l7_bus", werr, 0);
        check("l7_writes", wr_tot, NW);
        bad = 0;
        for (int k = 0; k < NW; k++)
            if (!written[WBASE + k] || wval[WBASE + k] !== 3'((k + 3) % 8)) bad++;
        check("l7_landed", bad, 0);
        check_scan("l7_scan", 640);
`ifdef FB_ARB_UNDERRUN_EN
        check("l7_no_underrun", underrun, 0);
`endif

        // Line 11: display enabled one clock after line_start -> underrun
        if (pix_en) step();
        start_line(11);
        de = 1'b1;
        steps(15);
        de = 1'b0;
        step();
        check("ur_count", cap.size(), 8);
        check("ur_pix0", cap[0], 0);
        check("ur_pix1", cap[1], 0);
        check("ur_pix2", cap[2], 1);
        check("ur_pix3", cap[3], 2);
        check("ur_first_addr", first_addr, 7040);
`ifdef FB_ARB_UNDERRUN_EN
        check("ur_flag", underrun, 1);
`endif

        // Line 20 aborted after ~100 reads, restarted at line 30
        start_line(20);
        de = 1'b1;
        for (int k = 0; k < 3000 && rd_cnt < 100; k++) step();
        check("ab_reached_100", rd_cnt >= 100, 1);
        de = 1'b0;
        start_line(30);
        steps(40);
        de = 1'b1;
        steps(1280);
        de = 1'b0;
        steps(10);
        check("ab_first_addr", first_addr, 19200);
        check("ab_reads", rd_cnt, 640);
        check("ab_seq", seq_err, 0);
        check_scan("ab_scan", 640);

        // Line 480: out of frame, no reads, writer always granted
        start_line(480);
        wr_valid = 1'b1;
        wr_addr = 19'd400000;
        wr_data = 3'd5;
        steps(50);
        check("vb_wr_ready", wr_ready, 1);
        check("vb_reads", rd_cnt, 0);
        check("vb_bus", werr, 0);
        wr_valid = 1'b0;

        // Reset in the middle of a fetch with pixels on screen
        start_line(2);
        steps(20);
        de = 1'b1;
        steps(4);
        de = 1'b0;
        check("mr_reads_started", rd_cnt > 0, 1);
        check("mr_rgb_before", rgb_out, 1);
        rst = 1'b0;
        step();
        check("mr_rgb", rgb_out, 0);
        check("mr_we", mem_we, 0);
        check("mr_addr", mem_addr, 0);
        check("mr_wr_ready", wr_ready, 0);
`ifdef FB_ARB_UNDERRUN_EN
        check("mr_underrun", underrun, 0);
`endif
        rst = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        steps(20);
        check("mr_idle_reads", rd_cnt, 0);
        check("mr_idle_wr_ready", wr_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
